// File: rtl/fft_stage_seq.sv
// fft_stage_seq: frame sequencer for the pipelined FFT datapath.
// Launches N = 2**LOG2N sample cycles on `start`, drives a shared sample
// counter plus one butterfly/bypass select per stage, then runs a
// FLUSH_CYC-cycle drain tail. Back-to-back frames chain at cnt == N-1.
// Optional feature: define FFT_SEQ_OVERRUN_EN to pulse `overrun` on rejected
// starts; otherwise `overrun` is tied low.
module fft_stage_seq #(
  parameter int unsigned LOG2N     = 3,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  output logic [LOG2N-1:0] cnt_out,
  output logic [LOG2N-1:0] bf_sel,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [LOG2N-1:0] CNT_LAST   = '1;
  localparam logic [7:0]       FLUSH_LAST = (FLUSH_CYC > 0) ? 8'(FLUSH_CYC - 1) : '0;

  state_t           state, state_nxt;
  logic [7:0]       fcnt, fcnt_nxt;
  logic [LOG2N-1:0] cnt_nxt, sel_nxt;
  logic             done_nxt;

  // Next-state, next-counter and next-select computation
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_out;
    fcnt_nxt  = fcnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (en) begin
          if (cnt_out == CNT_LAST) begin
            done_nxt = 1'b1;
            cnt_nxt  = '0;
            if (!start) begin
              if (FLUSH_CYC > 0) begin
                state_nxt = FLUSH;
                fcnt_nxt  = '0;
              end else begin
                state_nxt = IDLE;
              end
            end
          end else begin
            cnt_nxt = cnt_out + 1'b1;
          end
        end
      end
      FLUSH: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = RUN;
        end else if (en) begin
          // fcnt stops at its terminal value; the state change ends the tail
          if (fcnt == FLUSH_LAST) state_nxt = IDLE;
          else                    fcnt_nxt  = fcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Stage 0 has the largest span, so it follows the counter MSB
    sel_nxt = '0;
    if (state_nxt == RUN) begin
      for (int unsigned k = 0; k < LOG2N; k++) sel_nxt[k] = cnt_nxt[LOG2N-1-k];
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fcnt       <= '0;
      cnt_out    <= '0;
      bf_sel     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      fcnt       <= fcnt_nxt;
      cnt_out    <= cnt_nxt;
      bf_sel     <= sel_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
    end
  end

`ifdef FFT_SEQ_OVERRUN_EN
  // Flag starts arriving in RUN other than at an enabled last sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= (state == RUN) && start && !(en && (cnt_out == CNT_LAST));
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed testbench for fft_stage_seq (LOG2N=3, FLUSH_CYC=2).
module tb_fft_stage_seq;

  logic       clk, rst, start, en;
  logic [2:0] cnt_out, bf_sel;
  logic       busy, frame_done, overrun;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

`ifdef FFT_SEQ_OVERRUN_EN
  localparam int unsigned OVR = 1;
`else
  localparam int unsigned OVR = 0;
`endif

  // Hand-derived bf_sel for cnt 0..7 (bit k = cnt bit 2-k)
  int unsigned sel_tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_stage_seq #(.LOG2N(3), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .cnt_out(cnt_out), .bf_sel(bf_sel), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic launch;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("launch_cnt", cnt_out, 0);
    chk("launch_busy", busy, 1);
    chk("launch_sel", bf_sel, 0);
  endtask

  // Advance from cnt `from` to cnt `to`, checking counter and selects
  task automatic adv(input int unsigned from, input int unsigned to);
    for (int unsigned i = from + 1; i <= to; i++) begin
      step();
      chk("run_cnt", cnt_out, i);
      chk("run_sel", bf_sel, sel_tbl[i]);
      chk("run_done", frame_done, 0);
      chk("run_busy", busy, 1);
    end
  endtask

  // From cnt==7 with start low: done pulse, two flush cycles, idle
  task automatic drain;
    step();
    chk("end_done", frame_done, 1);
    chk("end_cnt", cnt_out, 0);
    chk("end_sel", bf_sel, 0);
    chk("flush1_busy", busy, 1);
    step();
    chk("flush2_done", frame_done, 0);
    chk("flush2_busy", busy, 1);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done", frame_done, 0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b1; en = 1'b1;
    #12;
    chk("rst_cnt", cnt_out, 0);
    chk("rst_sel", bf_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovr", overrun, 0);
    step();
    rst = 1'b0; start = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    // Basic frame with flush tail
    launch();
    adv(0, 7);
    drain();

    // Back-to-back: start held over the cnt==7 cycle
    launch();
    adv(0, 7);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_cnt", cnt_out, 0);
    chk("b2b_done", frame_done, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_ovr", overrun, 0);
    adv(0, 7);
    drain();

    // Stall for 3 cycles at cnt=3
    launch();
    adv(0, 3);
    en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("stall_cnt", cnt_out, 3);
      chk("stall_sel", bf_sel, 6);
      chk("stall_done", frame_done, 0);
    end
    en = 1'b1;
    adv(3, 7);
    drain();

    // Rejected start at cnt=2, then start with en=0 at cnt=7
    launch();
    adv(0, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rej_cnt", cnt_out, 3);
    chk("rej_ovr", overrun, OVR);
    step();
    chk("rej_ovr_clr", overrun, 0);
    chk("rej_cnt2", cnt_out, 4);
    adv(4, 7);
    en = 1'b0; start = 1'b1;
    step();
    en = 1'b1; start = 1'b0;
    chk("stall7_cnt", cnt_out, 7);
    chk("stall7_done", frame_done, 0);
    chk("stall7_ovr", overrun, OVR);
    drain();

    // Start in the first flush cycle abandons the flush
    launch();
    adv(0, 7);
    step();
    chk("fl_done", frame_done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fl_cnt", cnt_out, 0);
    chk("fl_busy", busy, 1);
    chk("fl_ovr", overrun, 0);
    adv(0, 7);
    drain();

    // Asynchronous reset at cnt=5
    launch();
    adv(0, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", cnt_out, 0);
    chk("arst_sel", bf_sel, 0);
    chk("arst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_done", frame_done, 0);
    chk("arst_idle_cnt", cnt_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
